masked_hpc1_rand_source: RTL and testbench



---
 rtl/masked_hpc1_rand_source_pkg.sv | 18 +
 rtl/masked_hpc1_rand_source_lfsr_multi_step.sv | 27 ++
 rtl/masked_hpc1_rand_source.sv | 118 +++++++++++
 tb/tb_masked_hpc1_rand_source.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_hpc1_rand_source_pkg.sv
// Shared constants and helpers for the masked-multiplier randomness source.
package masked_hpc1_rand_source_pkg;

    localparam int unsigned LFSR_WIDTH = 32;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [LFSR_WIDTH-1:0] LFSR_ZERO_SUB = 32'h0000_0001;

    typedef logic [1:0] rand_src_state_t;
    localparam rand_src_state_t UNSEEDED = 2'd0;
    localparam rand_src_state_t FILL     = 2'd1;
    localparam rand_src_state_t VALID    = 2'd2;

    // Number of share pairs, i.e. pairwise randomness terms of an HPC1 multiplier.
    function automatic int unsigned num_quad(input int unsigned n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/masked_hpc1_rand_source_lfsr_multi_step.sv
// Combinational unroll of STEPS Fibonacci LFSR steps; out_bits[0] is emitted first.
module lfsr_multi_step
    import masked_hpc1_rand_source_pkg::*;
#(
    parameter int unsigned STEPS = 1
) (
    input  logic [LFSR_WIDTH-1:0] in_state,
    output logic [LFSR_WIDTH-1:0] out_state,
    output logic [STEPS-1:0]      out_bits
);

    logic [LFSR_WIDTH-1:0] chain;
    logic                  fb;

    always_comb begin
        chain    = in_state;
        fb       = 1'b0;
        out_bits = '0;
        for (int i = 0; i < int'(STEPS); i++) begin
            fb          = ^(chain & LFSR_TAPS);
            out_bits[i] = fb;
            chain       = {chain[LFSR_WIDTH-2:0], fb};
        end
        out_state = chain;
    end

endmodule

// File: rtl/masked_hpc1_rand_source.sv
// Seeded LFSR that packs one refresh word and one pairwise word per handshake
// for an HPC1 masked multiplier.
module masked_hpc1_rand_source
    import masked_hpc1_rand_source_pkg::*;
#(
    parameter int unsigned NUM_SHARES = 2,
    parameter int unsigned BIT_WIDTH  = 1,
    parameter int unsigned GEN_BITS   = 1
) (
    input  logic                                          in_clock,
    input  logic                                          in_reset,
    input  logic [LFSR_WIDTH-1:0]                         in_seed,
    input  logic                                          in_seed_valid,
    output logic [NUM_SHARES*BIT_WIDTH-1:0]               out_r,
    output logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0]     out_p,
    output logic                                          out_valid,
    input  logic                                          in_ready,
    output logic                                          out_seeded
);

    localparam int unsigned R_BITS      = NUM_SHARES * BIT_WIDTH;
    localparam int unsigned P_BITS      = num_quad(NUM_SHARES) * BIT_WIDTH;
    localparam int unsigned OUT_BITS    = R_BITS + P_BITS;
    localparam int unsigned FILL_CYCLES = (OUT_BITS + GEN_BITS - 1) / GEN_BITS;
    localparam int unsigned BUF_BITS    = FILL_CYCLES * GEN_BITS;
    localparam int unsigned CNT_BITS    = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

    rand_src_state_t       state_q, state_d;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [BUF_BITS-1:0]   buf_q, buf_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [R_BITS-1:0]     r_d;
    logic [P_BITS-1:0]     p_d;
    logic                  valid_d;
    logic                  seeded_d;

    logic [LFSR_WIDTH-1:0] step_state;
    logic [GEN_BITS-1:0]   step_bits;

    lfsr_multi_step #(
        .STEPS (GEN_BITS)
    ) u_step (
        .in_state  (lfsr_q),
        .out_state (step_state),
        .out_bits  (step_bits)
    );

    // Next-state and registered-output logic; a seed load overrides everything else.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        r_d      = out_r;
        p_d      = out_p;
        valid_d  = out_valid;
        seeded_d = out_seeded;

        case (state_q)
            FILL: begin
                lfsr_d = step_state;
                buf_d[32'(cnt_q) * GEN_BITS +: GEN_BITS] = step_bits;
                if (cnt_q == CNT_BITS'(FILL_CYCLES - 1)) begin
                    r_d     = buf_d[R_BITS-1:0];
                    p_d     = buf_d[OUT_BITS-1:R_BITS];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = VALID;
                end else begin
                    cnt_d = CNT_BITS'(cnt_q + 1'b1);
                end
            end
            VALID: begin
                if (in_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    buf_d   = '0;
                    state_d = FILL;
                end
            end
            default: ;
        endcase

        if (in_seed_valid) begin
            lfsr_d   = (in_seed == '0) ? LFSR_ZERO_SUB : in_seed;
            buf_d    = '0;
            cnt_d    = '0;
            r_d      = '0;
            p_d      = '0;
            valid_d  = 1'b0;
            seeded_d = 1'b1;
            state_d  = FILL;
        end
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_q    <= UNSEEDED;
            lfsr_q     <= LFSR_ZERO_SUB;
            buf_q      <= '0;
            cnt_q      <= '0;
            out_r      <= '0;
            out_p      <= '0;
            out_valid  <= 1'b0;
            out_seeded <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            out_r      <= r_d;
            out_p      <= p_d;
            out_valid  <= valid_d;
            out_seeded <= seeded_d;
        end
    end

endmodule

// File: tb/tb_masked_hpc1_rand_source.sv
// Directed bench for masked_hpc1_rand_source: default and a wide configuration.
module tb_masked_hpc1_rand_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] seed_a, seed_b;
    logic        seed_valid_a, seed_valid_b;
    logic        ready_a, ready_b;
    logic [1:0]  r_a;
    logic [0:0]  p_a;
    logic        valid_a, seeded_a;
    logic [5:0]  r_b, p_b;
    logic        valid_b, seeded_b;

    int checks = 0;
    int errors = 0;
    logic [31:0] model;

    masked_hpc1_rand_source dut_a (
        .in_clock      (clk),
        .in_reset      (rst_n),
        .in_seed       (seed_a),
        .in_seed_valid (seed_valid_a),
        .out_r         (r_a),
        .out_p         (p_a),
        .out_valid     (valid_a),
        .in_ready      (ready_a),
        .out_seeded    (seeded_a)
    );

    masked_hpc1_rand_source #(
        .NUM_SHARES (3),
        .BIT_WIDTH  (2),
        .GEN_BITS   (4)
    ) dut_b (
        .in_clock      (clk),
        .in_reset      (rst_n),
        .in_seed       (seed_b),
        .in_seed_valid (seed_valid_b),
        .out_r         (r_b),
        .out_p         (p_b),
        .out_valid     (valid_b),
        .in_ready      (ready_b),
        .out_seeded    (seeded_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR: taps 31,21,1,0, first emitted bit at index 0.
    task automatic model_bits(input int n, output logic [31:0] bits);
        logic fb;
        bits = '0;
        for (int i = 0; i < n; i++) begin
            fb      = model[31] ^ model[21] ^ model[1] ^ model[0];
            bits[i] = fb;
            model   = {model[30:0], fb};
        end
    endtask

    task automatic wait_valid_a(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_a && n < 50);
    endtask

    task automatic wait_valid_b(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_b && n < 50);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        seed_a = '0; seed_valid_a = 1'b0; ready_a = 1'b0;
        seed_b = '0; seed_valid_b = 1'b0; ready_b = 1'b0;
        tick(); tick();
        checks++;
        if ({valid_a, seeded_a, r_a, p_a} !== 5'b0) begin
            errors++;
            $display("FAIL reset_a: got valid=%b seeded=%b r=%b p=%b, expected all 0", valid_a, seeded_a, r_a, p_a);
        end
        checks++;
        if ({valid_b, seeded_b, r_b, p_b} !== 14'b0) begin
            errors++;
            $display("FAIL reset_b: got valid=%b seeded=%b r=%h p=%h, expected all 0", valid_b, seeded_b, r_b, p_b);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_seed_one();
        int n;
        seed_a = 32'h0000_0001; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        checks++;
        if (valid_a !== 1'b0 || seeded_a !== 1'b1) begin
            errors++;
            $display("FAIL seed_one_load: got valid=%b seeded=%b, expected 0 1", valid_a, seeded_a);
        end
        wait_valid_a(n);
        checks++;
        if (n !== 3 || valid_a !== 1'b1) begin
            errors++;
            $display("FAIL seed_one_latency: got %0d cycles valid=%b, expected 3 cycles valid=1", n, valid_a);
        end
        checks++;
        if (r_a !== 2'b01 || p_a !== 1'b1) begin
            errors++;
            $display("FAIL seed_one_word: got r=%b p=%b, expected r=01 p=1", r_a, p_a);
        end
        checks++;
        if (dut_a.lfsr_q !== 32'h0000_000D) begin
            errors++;
            $display("FAIL seed_one_lfsr: got %h, expected 0000000d", dut_a.lfsr_q);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid_a !== 1'b1 || r_a !== 2'b01 || p_a !== 1'b1 || dut_a.lfsr_q !== 32'h0000_000D) begin
                errors++;
                $display("FAIL seed_one_hold[%0d]: got valid=%b r=%b p=%b lfsr=%h, expected 1 01 1 0000000d",
                         i, valid_a, r_a, p_a, dut_a.lfsr_q);
            end
        end
    endtask

    task automatic test_zero_seed();
        int n;
        seed_a = 32'h0; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        checks++;
        if (valid_a !== 1'b0 || r_a !== 2'b00 || p_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_seed_clear: got valid=%b r=%b p=%b, expected 0 00 0", valid_a, r_a, p_a);
        end
        wait_valid_a(n);
        checks++;
        if (n !== 3 || r_a !== 2'b01 || p_a !== 1'b1) begin
            errors++;
            $display("FAIL zero_seed_word: got %0d cycles r=%b p=%b, expected 3 cycles r=01 p=1", n, r_a, p_a);
        end
    endtask

    task automatic test_seed_and_accept();
        int n;
        ready_a = 1'b1; seed_a = 32'h0000_0002; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0; ready_a = 1'b0;
        checks++;
        if (valid_a !== 1'b0 || seeded_a !== 1'b1) begin
            errors++;
            $display("FAIL seed_accept_drop: got valid=%b seeded=%b, expected 0 1", valid_a, seeded_a);
        end
        wait_valid_a(n);
        checks++;
        if (n !== 3 || r_a !== 2'b11 || p_a !== 1'b0) begin
            errors++;
            $display("FAIL seed_accept_word: got %0d cycles r=%b p=%b, expected 3 cycles r=11 p=0", n, r_a, p_a);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] bits;
        seed_a = 32'hACE1_2345; seed_valid_a = 1'b1; ready_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        model = 32'hACE1_2345;
        for (int w = 0; w < 1000; w++) begin
            wait_valid_a(n);
            model_bits(3, bits);
            checks++;
            if (valid_a !== 1'b1 || {p_a, r_a} !== bits[2:0]) begin
                errors++;
                $display("FAIL stream_word[%0d]: got valid=%b word=%b, expected valid=1 word=%b", w, valid_a, {p_a, r_a}, bits[2:0]);
            end
            checks++;
            if (n !== ((w == 0) ? 3 : 4)) begin
                errors++;
                $display("FAIL stream_interval[%0d]: got %0d cycles, expected %0d", w, n, (w == 0) ? 3 : 4);
            end
        end
        ready_a = 1'b0;
    endtask

    task automatic test_reload_mid_fill();
        int n;
        seed_a = 32'h0000_0001; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        tick();
        seed_a = 32'h0000_0002; seed_valid_a = 1'b1;
        tick();
        seed_valid_a = 1'b0;
        wait_valid_a(n);
        checks++;
        if (n !== 3 || r_a !== 2'b11 || p_a !== 1'b0) begin
            errors++;
            $display("FAIL reload_word: got %0d cycles r=%b p=%b, expected 3 cycles r=11 p=0", n, r_a, p_a);
        end
        checks++;
        if (dut_a.lfsr_q !== 32'h0000_0016) begin
            errors++;
            $display("FAIL reload_lfsr: got %h, expected 00000016", dut_a.lfsr_q);
        end
    endtask

    task automatic test_wide();
        int n;
        logic [31:0] bits;
        seed_b = 32'h0000_0001; seed_valid_b = 1'b1;
        tick();
        seed_valid_b = 1'b0;
        wait_valid_b(n);
        checks++;
        if (n !== 3 || r_b !== 6'h2D || p_b !== 6'h2D) begin
            errors++;
            $display("FAIL wide_word: got %0d cycles r=%h p=%h, expected 3 cycles r=2d p=2d", n, r_b, p_b);
        end
        checks++;
        if (dut_b.lfsr_q !== 32'h0000_1B6D) begin
            errors++;
            $display("FAIL wide_lfsr: got %h, expected 00001b6d", dut_b.lfsr_q);
        end
        model = 32'h0000_1B6D;
        ready_b = 1'b1;
        wait_valid_b(n);
        ready_b = 1'b0;
        model_bits(12, bits);
        checks++;
        if (n !== 4 || {p_b, r_b} !== bits[11:0]) begin
            errors++;
            $display("FAIL wide_second: got %0d cycles word=%h, expected 4 cycles word=%h", n, {p_b, r_b}, bits[11:0]);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({valid_a, seeded_a, r_a, p_a} !== 5'b0 || dut_a.lfsr_q !== 32'h1) begin
            errors++;
            $display("FAIL async_reset_a: got valid=%b seeded=%b r=%b p=%b lfsr=%h, expected zeros lfsr=1",
                     valid_a, seeded_a, r_a, p_a, dut_a.lfsr_q);
        end
        checks++;
        if ({valid_b, seeded_b, r_b, p_b} !== 14'b0) begin
            errors++;
            $display("FAIL async_reset_b: got valid=%b seeded=%b r=%h p=%h, expected all 0", valid_b, seeded_b, r_b, p_b);
        end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_seed_one();
        test_zero_seed();
        test_seed_and_accept();
        test_back_to_back();
        test_reload_mid_fill();
        test_wide();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
